// File: rtl/bcd_pkg.sv
// Shared BCD definitions: converter state encoding, adjust constant and digit check.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ADJUST,
        DONE
    } state_t;

    localparam logic [3:0] BCD_ADJ = 4'd3;

    function automatic logic bcd_digit_valid(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// One BCD digit correction step of reverse double-dabble: digits >= 8 lose 3.
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd8) ? (d - BCD_ADJ) : d;

endmodule

// File: rtl/bcd2binary.sv
// Sequential packed-BCD to binary converter (reverse double-dabble) with start/busy/done.
//
// state  | meaning
// IDLE   | waiting for start; validates digits and loads work
// SHIFT  | shift work right by one, count iteration
// ADJUST | subtract 3 from every BCD digit >= 8
// DONE   | register bin_out/err and pulse done
module bcd2binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [DIGITS*4-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W  = DIGITS * 4;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    state_t             state, state_nxt;
    logic [WORK_W-1:0]  work;
    logic [CNT_W-1:0]   cnt;
    logic               err_pend;
    logic               all_valid;
    logic [BCD_W-1:0]   bcd_adj;

    always_comb begin
        all_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(bcd_in[4*i +: 4]))
                all_valid = 1'b0;
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_sub3 u_sub3 (
            .d (work[BIN_W + 4*gi +: 4]),
            .q (bcd_adj[4*gi +: 4])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = all_valid ? SHIFT : DONE;
            SHIFT:   state_nxt = ADJUST;
            ADJUST:  state_nxt = (cnt == CNT_W'(BIN_W)) ? DONE : SHIFT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath; the invalid-input path skips loading work and reports through err_pend.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            work     <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
            done     <= 1'b0;
            bin_out  <= '0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (all_valid)
                            work <= {bcd_in, {BIN_W{1'b0}}};
                        cnt      <= '0;
                        err_pend <= ~all_valid;
                    end
                end
                SHIFT: begin
                    work <= work >> 1;
                    cnt  <= cnt + 1'b1;
                end
                ADJUST: begin
                    work <= {bcd_adj, work[BIN_W-1:0]};
                end
                DONE: begin
                    done    <= 1'b1;
                    bin_out <= err_pend ? '0 : work[BIN_W-1:0];
                    err     <= err_pend;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd2binary.sv
// Randomised self-checking bench for bcd2binary against an arithmetic BCD decode model.
module tb_bcd2binary;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int LAT    = 2*BIN_W + 1;

    logic              sys_clk;
    logic              sys_rst_n;
    logic              start;
    logic [11:0]       bcd_in;
    logic              busy;
    logic              done;
    logic [BIN_W-1:0]  bin_out;
    logic              err;

    int tests;
    int fails;

    bcd2binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .bin_out   (bin_out),
        .err       (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference: decimal value of the digits, flagged bad if any digit exceeds 9.
    function automatic void ref_conv(input logic [11:0] b, output int val, output bit bad);
        int d;
        int scale;
        val   = 0;
        bad   = 1'b0;
        scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((b >> (4*i)) & 12'hF);
            if (d > 9) bad = 1'b1;
            val   = val + d * scale;
            scale = scale * 10;
        end
        if (bad) val = 0;
    endfunction

    function automatic logic [11:0] rand_valid();
        logic [11:0] b;
        b = '0;
        for (int i = 0; i < DIGITS; i++)
            b = b | (12'($urandom_range(0, 9)) << (4*i));
        return b;
    endfunction

    function automatic logic [11:0] rand_invalid();
        logic [11:0] b;
        int          pos;
        b   = rand_valid();
        pos = int'($urandom_range(0, DIGITS-1));
        b   = b & ~(12'hF << (4*pos));
        b   = b | (12'($urandom_range(10, 15)) << (4*pos));
        return b;
    endfunction

    // Runs one conversion from an idle DUT; lat counts edges after the accepting edge.
    task automatic convert(input logic [11:0] v, output logic [BIN_W-1:0] res, output logic e,
                           output int lat, output int busy_cnt, output bit timeout);
        @(negedge sys_clk);
        bcd_in = v;
        start  = 1'b1;
        @(negedge sys_clk);
        start    = 1'b0;
        bcd_in   = ~v;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(negedge sys_clk);
            lat++;
            if (busy) busy_cnt++;
        end
        timeout = !done;
        res     = bin_out;
        e       = err;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        start     = 1'b0;
        bcd_in    = '0;
        repeat (3) @(negedge sys_clk);
        tests++;
        if ({busy, done, err, bin_out} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b bin=%0d, want all 0",
                     busy, done, err, bin_out);
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_basic();
        logic [BIN_W-1:0] res;
        logic e;
        int lat, bc, exp_v;
        bit to, bad;
        ref_conv(12'h255, exp_v, bad);
        convert(12'h255, res, e, lat, bc, to);
        tests++;
        if (to || lat != LAT || bc != LAT) begin
            fails++;
            $display("FAIL basic_timing: got lat=%0d busy_cycles=%0d timeout=%0b, want %0d/%0d/0",
                     lat, bc, to, LAT, LAT);
        end
        tests++;
        if (res !== BIN_W'(exp_v) || e !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_value: got bin=%0d err=%0b busy=%0b, want %0d/0/0", res, e, busy, exp_v);
        end
        @(negedge sys_clk);
        tests++;
        if (done !== 1'b0 || bin_out !== BIN_W'(exp_v)) begin
            fails++;
            $display("FAIL done_pulse_hold: got done=%0b bin=%0d, want 0/%0d", done, bin_out, exp_v);
        end
    endtask

    task automatic test_boundary();
        logic [11:0] vals [3];
        logic [BIN_W-1:0] res;
        logic e;
        int lat, bc, exp_v;
        bit to, bad;
        vals[0] = 12'h000; vals[1] = 12'h999; vals[2] = 12'h001;
        for (int i = 0; i < 3; i++) begin
            ref_conv(vals[i], exp_v, bad);
            convert(vals[i], res, e, lat, bc, to);
            tests++;
            if (to || res !== BIN_W'(exp_v) || e !== 1'b0 || lat != LAT) begin
                fails++;
                $display("FAIL boundary_%03h: got bin=%0d err=%0b lat=%0d, want %0d/0/%0d",
                         vals[i], res, e, lat, exp_v, LAT);
            end
        end
    endtask

    task automatic test_invalid();
        logic [BIN_W-1:0] res;
        logic e;
        int lat, bc, exp_v;
        bit to, bad;
        convert(12'h1A5, res, e, lat, bc, to);
        tests++;
        if (to || lat != 1 || bc != 1 || res !== '0 || e !== 1'b1) begin
            fails++;
            $display("FAIL invalid_1A5: got lat=%0d busy=%0d bin=%0d err=%0b, want 1/1/0/1",
                     lat, bc, res, e);
        end
        ref_conv(12'h042, exp_v, bad);
        convert(12'h042, res, e, lat, bc, to);
        tests++;
        if (to || res !== BIN_W'(exp_v) || e !== 1'b0) begin
            fails++;
            $display("FAIL after_invalid_042: got bin=%0d err=%0b, want %0d/0", res, e, exp_v);
        end
    endtask

    // start held high: each accept follows the previous done, so accepts are LAT+1 edges apart.
    task automatic test_back_to_back();
        logic [11:0] v [100];
        int n_done, exp_v, acc;
        bit bad;
        n_done = 0;
        @(negedge sys_clk);
        start = 1'b1;
        for (int e = 0; e < 100; e++) begin
            if (e > 0) @(negedge sys_clk);
            if (e > 0 && done) begin
                acc = (e - 1) - LAT;
                tests++;
                if (acc != n_done * (LAT + 1)) begin
                    fails++;
                    $display("FAIL b2b_spacing: done at edge %0d, want edge %0d",
                             e - 1, n_done * (LAT + 1) + LAT);
                end else begin
                    ref_conv(v[acc], exp_v, bad);
                    tests++;
                    if (bin_out !== BIN_W'(exp_v) || err !== 1'b0) begin
                        fails++;
                        $display("FAIL b2b_value: got bin=%0d err=%0b, want %0d/0", bin_out, err, exp_v);
                    end
                end
                n_done++;
            end
            v[e]   = rand_valid();
            bcd_in = v[e];
        end
        start = 1'b0;
        tests++;
        if (n_done != 4) begin
            fails++;
            $display("FAIL b2b_count: got %0d done pulses, want 4", n_done);
        end
        repeat (LAT + 2) @(negedge sys_clk);
    endtask

    task automatic test_reset_mid();
        logic [BIN_W-1:0] res;
        logic e;
        int lat, bc, exp_v, seen;
        bit to, bad;
        @(negedge sys_clk);
        bcd_in = 12'h987;
        start  = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (8) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, err, bin_out} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got busy=%0b done=%0b err=%0b bin=%0d, want all 0",
                     busy, done, err, bin_out);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (done || busy) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: got %0d busy/done cycles, want 0", seen);
        end
        ref_conv(12'h123, exp_v, bad);
        convert(12'h123, res, e, lat, bc, to);
        tests++;
        if (to || res !== BIN_W'(exp_v) || e !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_123: got bin=%0d err=%0b, want %0d/0", res, e, exp_v);
        end
    endtask

    task automatic test_sweep();
        logic [11:0] b;
        logic [BIN_W-1:0] res;
        logic e;
        int lat, bc, exp_v;
        bit to, bad;
        for (int n = 0; n < 1000 + 60; n++) begin
            if (n < 1000)
                b = 12'((n / 100) << 8) | 12'(((n / 10) % 10) << 4) | 12'(n % 10);
            else
                b = rand_invalid();
            ref_conv(b, exp_v, bad);
            convert(b, res, e, lat, bc, to);
            tests++;
            if (to || res !== BIN_W'(exp_v) || e !== bad) begin
                fails++;
                $display("FAIL sweep_%03h: got bin=%0d err=%0b timeout=%0b, want %0d/%0b",
                         b, res, e, to, exp_v, bad);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
